// File: rtl/cybercobra_io_pkg.sv
// cybercobra_io_pkg: shared 7-segment constants (hex font, digit count, blank code)
package cybercobra_io_pkg;
  localparam int NUM_DIGITS = 8;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_BLANK = 7'h7F;
  localparam seg_t SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
endpackage

// File: rtl/cybercobra_board_io_sw_debouncer.sv
// sw_debouncer: 2-flop sync + whole-vector debounce; clk_i, rst_i, raw_i[WIDTH] in, sw_o[WIDTH] out
module sw_debouncer #(
  parameter int WIDTH  = 16,
  parameter int CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] sw_o
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [WIDTH-1:0] s1, s2, prev;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
      cnt  <= '0;
      sw_o <= '0;
    end else begin
      s1   <= raw_i;
      s2   <= s1;
      prev <= s2;
      if (s2 != prev) cnt <= '0;
      else if (s2 != sw_o) begin
        if (cnt == CW'(CYCLES - 1)) begin
          sw_o <= s2;
          cnt  <= '0;
        end else cnt <= cnt + 1'b1;
      end else cnt <= '0;
    end
  end
endmodule

// File: rtl/cybercobra_board_io.sv
// cybercobra_board_io: debounced sw_o from sw_raw_i; value_i scanned onto 8-digit 7-seg (an_o, seg_o active-low)
module cybercobra_board_io
  import cybercobra_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SCAN_CYCLES     = 8,
  parameter int LZ_BLANK        = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] sw_raw_i,
  output logic [15:0] sw_o,
  input  logic [31:0] value_i,
  output logic [7:0]  an_o,
  output seg_t        seg_o
);
  localparam int SW = $clog2(SCAN_CYCLES);
  logic [SW-1:0] scan_cnt;
  logic [2:0] digit;
  logic [31:0] shadow;
  logic wrap, blank;
  logic [3:0] nib;
  sw_debouncer #(.WIDTH(16), .CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .raw_i(sw_raw_i),
    .sw_o (sw_o)
  );
  always_comb begin
    wrap  = scan_cnt == SW'(SCAN_CYCLES - 1);
    nib   = shadow[{digit, 2'b00} +: 4];
    blank = LZ_BLANK != 0 && digit != 3'd0 && (shadow >> {digit, 2'b00}) == 32'd0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scan_cnt <= '0;
      digit    <= '0;
      shadow   <= '0;
      an_o     <= 8'hFF;
      seg_o    <= SEG_BLANK;
    end else begin
      scan_cnt <= wrap ? '0 : scan_cnt + 1'b1;
      if (wrap) digit <= digit + 3'd1;
      if (wrap && digit == 3'(NUM_DIGITS - 1)) shadow <= value_i;
      an_o  <= blank ? 8'hFF : ~(8'd1 << digit);
      seg_o <= blank ? SEG_BLANK : SEG_LUT[nib];
    end
  end
endmodule
